// File: rtl/sar_host_if.sv
// Link between the host and an asynchronous SAR controller: toggle-based
// start/end-of-conversion handshake, error/warning toggles and the code bus.
interface sar_host_if #(
  parameter int NSTEP = 10
);
  logic             soc;
  logic             eoc;
  logic             err;
  logic             warn;
  logic [NSTEP-1:0] code;

  modport master (output soc, input eoc, err, warn, code);
  modport slave  (input soc, output eoc, err, warn, code);
endinterface

// File: rtl/sar_host.sv
// Oversampling host for a toggle-handshake SAR controller: requests
// 2^OSR_LOG2 conversions, accumulates them and publishes sum and average.
module sar_host #(
  parameter int NSTEP    = 10,
  parameter int OSR_LOG2 = 2,
  parameter int TMO_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      abort_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [NSTEP+OSR_LOG2-1:0] result_o,
  output logic [NSTEP-1:0]          avg_o,
  output logic                      err_o,
  output logic                      tmo_o,
  output logic [3:0]                warnCnt_o,
  sar_host_if.master                sar
);

  localparam int ACCW  = NSTEP + OSR_LOG2;
  localparam int NSAMP = 1 << OSR_LOG2;
  localparam logic [OSR_LOG2:0] LAST = (OSR_LOG2+1)'(NSAMP - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, ACC, DONE} state_e;

  state_e              state_q, state_d;
  logic [2:0]          eocSync_q, errSync_q, warnSync_q;
  logic                soc_q, soc_d;
  logic [TMO_W-1:0]    tmoCnt_q, tmoCnt_d;
  logic [NSTEP-1:0]    codeCapt_q, codeCapt_d;
  logic [ACCW-1:0]     acc_q, acc_d;
  logic [OSR_LOG2:0]   sampleCnt_q, sampleCnt_d;
  logic [ACCW-1:0]     result_q, result_d;
  logic [NSTEP-1:0]    avg_q, avg_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                tmo_q, tmo_d;
  logic [3:0]          warnCnt_q, warnCnt_d;

  // Any difference between the second and third flop is one toggle event.
  logic eocEvt, errEvt, warnEvt;
  assign eocEvt  = eocSync_q[1]  ^ eocSync_q[2];
  assign errEvt  = errSync_q[1]  ^ errSync_q[2];
  assign warnEvt = warnSync_q[1] ^ warnSync_q[2];

  always_comb begin
    state_d     = state_q;
    soc_d       = soc_q;
    tmoCnt_d    = tmoCnt_q;
    codeCapt_d  = codeCapt_q;
    acc_d       = acc_q;
    sampleCnt_d = sampleCnt_q;
    result_d    = result_q;
    avg_d       = avg_q;
    done_d      = 1'b0;
    err_d       = err_q;
    tmo_d       = tmo_q;
    warnCnt_d   = warnCnt_q;

    if (errEvt || (eocEvt && state_q != WAIT)) err_d = 1'b1;
    if (warnEvt && warnCnt_q != 4'hF) warnCnt_d = warnCnt_q + 4'd1;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d     = REQ;
          acc_d       = '0;
          sampleCnt_d = '0;
          err_d       = 1'b0;
          tmo_d       = 1'b0;
          warnCnt_d   = '0;
        end
      end
      REQ: begin
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          soc_d    = ~soc_q;
          tmoCnt_d = '1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        // Abort wins over a coincident end-of-conversion.
        if (abort_i) begin
          state_d = IDLE;
        end else if (eocEvt) begin
          codeCapt_d = sar.code;
          state_d    = ACC;
        end else if (tmoCnt_q == '0) begin
          tmo_d   = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmoCnt_d = tmoCnt_q - TMO_W'(1);
        end
      end
      ACC: begin
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          acc_d       = acc_q + ACCW'(codeCapt_q);
          sampleCnt_d = sampleCnt_q + (OSR_LOG2+1)'(1);
          state_d     = (sampleCnt_q == LAST) ? DONE : REQ;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!abort_i) begin
          result_d = acc_q;
          avg_d    = acc_q[ACCW-1 -: NSTEP];
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      eocSync_q   <= '0;
      errSync_q   <= '0;
      warnSync_q  <= '0;
      soc_q       <= 1'b0;
      tmoCnt_q    <= '0;
      codeCapt_q  <= '0;
      acc_q       <= '0;
      sampleCnt_q <= '0;
      result_q    <= '0;
      avg_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
      warnCnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      eocSync_q   <= {eocSync_q[1:0], sar.eoc};
      errSync_q   <= {errSync_q[1:0], sar.err};
      warnSync_q  <= {warnSync_q[1:0], sar.warn};
      soc_q       <= soc_d;
      tmoCnt_q    <= tmoCnt_d;
      codeCapt_q  <= codeCapt_d;
      acc_q       <= acc_d;
      sampleCnt_q <= sampleCnt_d;
      result_q    <= result_d;
      avg_q       <= avg_d;
      done_q      <= done_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      warnCnt_q   <= warnCnt_d;
    end
  end

  assign sar.soc   = soc_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;
  assign result_o  = result_q;
  assign avg_o     = avg_q;
  assign err_o     = err_q;
  assign tmo_o     = tmo_q;
  assign warnCnt_o = warnCnt_q;

endmodule
